// File: rtl/cic_interpolator.sv
// Five-stage CIC interpolator: low-rate comb section, zero-stuff by R, five
// full-rate integrators, then arithmetic scaling and 8-bit saturation.
module cic_interpolator #(
  parameter int WIDTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       interpolation_ratio,
  input  logic [5:0]        gain_shift,
  input  logic signed [7:0] d_in,
  output logic              d_req,
  output logic signed [7:0] d_out,
  output logic              sat
);

  localparam int N = 5;
  typedef logic signed [WIDTH-1:0] acc_t;
  localparam acc_t MAX_OUT = acc_t'(127);
  localparam acc_t MIN_OUT = acc_t'(-128);

  logic [15:0]       r_eff;
  logic [15:0]       count_q, count_d;
  logic              d_req_q, d_req_d;
  logic              stuff_q, stuff_d;
  acc_t              x_q, x_d;
  acc_t              x_dly_q, x_dly_d;
  acc_t              c_q [N];
  acc_t              c_d [N];
  acc_t              c_dly_q [N-1];
  acc_t              c_dly_d [N-1];
  acc_t              i_q [N];
  acc_t              i_d [N];
  acc_t              u;
  acc_t              s;
  logic signed [7:0] d_out_q, d_out_d;
  logic              sat_q, sat_d;

  // Ratio counter: >= compare keeps a shrinking ratio from locking up.
  always_comb begin
    r_eff = (interpolation_ratio == 16'd0) ? 16'd1 : interpolation_ratio;
    if (count_q >= r_eff - 16'd1) begin
      count_d = '0;
      d_req_d = 1'b1;
    end else begin
      count_d = count_q + 16'd1;
      d_req_d = 1'b0;
    end
    stuff_d = d_req_q;
  end

  always_comb begin
    x_d     = x_q;
    x_dly_d = x_dly_q;
    c_d     = c_q;
    c_dly_d = c_dly_q;
    if (d_req_q) begin
      x_d        = {{(WIDTH-8){d_in[7]}}, d_in};
      x_dly_d    = x_q;
      c_d[0]     = x_q - x_dly_q;
      c_dly_d[0] = c_q[0];
      for (int k = 1; k < N; k++) begin
        c_d[k] = c_q[k-1] - c_dly_q[k-1];
        if (k < N - 1) c_dly_d[k] = c_q[k];
      end
    end
  end

  always_comb begin
    u      = stuff_q ? c_q[N-1] : '0;
    i_d[0] = i_q[0] + u;
    for (int k = 1; k < N; k++) i_d[k] = i_q[k] + i_q[k-1];
  end

  always_comb begin
    s       = i_q[N-1] >>> gain_shift;
    d_out_d = s[7:0];
    sat_d   = 1'b0;
    if (s > MAX_OUT) begin
      d_out_d = 8'sd127;
      sat_d   = 1'b1;
    end else if (s < MIN_OUT) begin
      d_out_d = -8'sd128;
      sat_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      d_req_q <= 1'b0;
      stuff_q <= 1'b0;
      x_q     <= '0;
      x_dly_q <= '0;
      for (int k = 0; k < N; k++) begin
        c_q[k] <= '0;
        i_q[k] <= '0;
      end
      for (int k = 0; k < N - 1; k++) c_dly_q[k] <= '0;
      d_out_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      d_req_q <= d_req_d;
      stuff_q <= stuff_d;
      x_q     <= x_d;
      x_dly_q <= x_dly_d;
      for (int k = 0; k < N; k++) begin
        c_q[k] <= c_d[k];
        i_q[k] <= i_d[k];
      end
      for (int k = 0; k < N - 1; k++) c_dly_q[k] <= c_dly_d[k];
      d_out_q <= d_out_d;
      sat_q   <= sat_d;
    end
  end

  assign d_req = d_req_q;
  assign d_out = d_out_q;
  assign sat   = sat_q;

endmodule
